// File: rtl/gemm_insn_issue_if.sv
// rtl/gemm_insn_issue_if.sv - upstream instruction stream into the gemm issuer
interface gemm_insn_issue_if #(
  parameter int INS_WIDTH = 128
);
  logic                 s_insn_valid;
  logic                 s_insn_ready;
  logic [INS_WIDTH-1:0] s_insn_data;

  modport master (output s_insn_valid, output s_insn_data, input s_insn_ready);
  modport slave  (input s_insn_valid, input s_insn_data, output s_insn_ready);
endinterface

// File: rtl/gemm_insn_issue.sv
// rtl/gemm_insn_issue.sv - dependency-aware GEMM instruction issuer with load/store token counters
// Optional one-entry skid buffer enabled by GEMM_ISSUE_SKID_EN.
module gemm_insn_issue #(
  parameter int INS_WIDTH     = 128,
  parameter int TOK_CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gemm_insn_issue_if.slave     s_insn,
  input  logic                 prev_tok_in,
  input  logic                 next_tok_in,
  output logic                 prev_tok_out,
  output logic                 next_tok_out,
  output logic [INS_WIDTH-1:0] insn,
  output logic                 insn_valid,
  input  logic                 gemm_done,
  output logic                 busy,
  output logic                 tok_overflow
);
  typedef enum logic [1:0] {IDLE, WAIT_DEP, ISSUE, PUSH} state_t;

  localparam logic [TOK_CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                   state, state_nxt;
  logic [TOK_CNT_WIDTH-1:0] prev_cnt, next_cnt;
  logic                     accept, dep_ok, do_pop, load_insn;
  logic                     prev_dec, next_dec, ovf_set;

`ifdef GEMM_ISSUE_SKID_EN
  logic                 skid_full;
  logic [INS_WIDTH-1:0] skid_data;
  logic                 skid_load, skid_to_insn;

  assign s_insn.s_insn_ready = !skid_full;
  assign busy                = (state != IDLE) || skid_full;
`else
  assign s_insn.s_insn_ready = (state == IDLE);
  assign busy                = (state != IDLE);
`endif

  assign accept   = s_insn.s_insn_valid && s_insn.s_insn_ready;
  assign dep_ok   = (!insn[3] || (prev_cnt != '0)) && (!insn[4] || (next_cnt != '0));
  assign prev_dec = do_pop && insn[3];
  assign next_dec = do_pop && insn[4];
  assign ovf_set  = (prev_tok_in && !prev_dec && (prev_cnt == CNT_MAX)) ||
                    (next_tok_in && !next_dec && (next_cnt == CNT_MAX));

  always_comb begin
    state_nxt = state;
    load_insn = 1'b0;
    do_pop    = 1'b0;
`ifdef GEMM_ISSUE_SKID_EN
    skid_to_insn = 1'b0;
    skid_load    = accept && (state != IDLE);
`endif
    case (state)
      IDLE: begin
`ifdef GEMM_ISSUE_SKID_EN
        // A skid entry caught on the PUSH->IDLE edge is drained here instead of being stranded.
        if (skid_full) begin
          skid_to_insn = 1'b1;
          state_nxt    = WAIT_DEP;
        end else
`endif
        if (accept) begin
          load_insn = 1'b1;
          state_nxt = WAIT_DEP;
        end
      end
      WAIT_DEP: begin
        if (dep_ok) begin
          do_pop    = 1'b1;
          state_nxt = (insn[2:0] == 3'h2) ? ISSUE : PUSH;
        end
      end
      ISSUE: begin
        if (gemm_done) state_nxt = PUSH;
      end
      PUSH: begin
        state_nxt = IDLE;
`ifdef GEMM_ISSUE_SKID_EN
        if (skid_full) begin
          skid_to_insn = 1'b1;
          state_nxt    = WAIT_DEP;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insn <= '0;
    end else if (load_insn) begin
      insn <= s_insn.s_insn_data;
`ifdef GEMM_ISSUE_SKID_EN
    end else if (skid_to_insn) begin
      insn <= skid_data;
`endif
    end
  end

`ifdef GEMM_ISSUE_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_full <= 1'b1;
      skid_data <= s_insn.s_insn_data;
    end else if (skid_to_insn) begin
      skid_full <= 1'b0;
    end
  end
`endif

  // Counters saturate; a same-cycle grant and pop cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt <= '0;
      next_cnt <= '0;
    end else begin
      if (prev_tok_in && !prev_dec && (prev_cnt != CNT_MAX)) prev_cnt <= prev_cnt + 1'b1;
      else if (prev_dec && !prev_tok_in)                     prev_cnt <= prev_cnt - 1'b1;
      if (next_tok_in && !next_dec && (next_cnt != CNT_MAX)) next_cnt <= next_cnt + 1'b1;
      else if (next_dec && !next_tok_in)                     next_cnt <= next_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tok_overflow <= 1'b0;
    else if (ovf_set) tok_overflow <= 1'b1;
  end

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insn_valid   <= 1'b0;
      prev_tok_out <= 1'b0;
      next_tok_out <= 1'b0;
    end else begin
      insn_valid   <= (state == ISSUE);
      prev_tok_out <= (state == PUSH) && insn[5];
      next_tok_out <= (state == PUSH) && insn[6];
    end
  end
endmodule

// File: tb/tb_gemm_insn_issue.sv
// tb/tb_gemm_insn_issue.sv - scoreboard bench for gemm_insn_issue with directed and random stimulus
module tb_gemm_insn_issue;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         prev_tok_in = 1'b0, next_tok_in = 1'b0, gemm_done = 1'b0;
  logic         prev_tok_out, next_tok_out, insn_valid, busy, tok_overflow;
  logic [127:0] insn;

  gemm_insn_issue_if #(.INS_WIDTH(128)) s_if ();

  gemm_insn_issue dut (
    .clk(clk), .rst(rst), .s_insn(s_if),
    .prev_tok_in(prev_tok_in), .next_tok_in(next_tok_in),
    .prev_tok_out(prev_tok_out), .next_tok_out(next_tok_out),
    .insn(insn), .insn_valid(insn_valid), .gemm_done(gemm_done),
    .busy(busy), .tok_overflow(tok_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, done_cyc = -1, last_prev_cyc = -1, last_next_cyc = -1;
  int n_prev = 0, n_next = 0;
  int done_dly = 5;
  bit done_en = 1'b1, rand_tok = 1'b0;
  logic [128:0] exp_q[$];

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one instruction yields an issue event (GEMM only) then a push event (if any bit set).
  task automatic model_push(input logic [127:0] d);
    if (d[2:0] == 3'h2) exp_q.push_back({1'b0, d});
    if (d[5] || d[6])   exp_q.push_back({1'b1, 126'b0, d[6], d[5]});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (gemm_done) done_cyc = cyc;
  end

  initial begin : monitor
    logic         iv_q;
    logic [128:0] ev, ex;
    iv_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        iv_q = 1'b0;
      end else begin
        if (prev_tok_out || next_tok_out) begin
          if (prev_tok_out) begin n_prev++; last_prev_cyc = cyc; end
          if (next_tok_out) begin n_next++; last_next_cyc = cyc; end
          ev = {1'b1, 126'b0, next_tok_out, prev_tok_out};
          ex = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          chk("sb_push_event", ev, ex);
        end
        if (insn_valid && !iv_q) begin
          ev = {1'b0, insn};
          ex = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          chk("sb_issue_event", ev, ex);
        end
        iv_q = insn_valid;
      end
    end
  end

  initial begin : responder
    forever begin
      @(negedge clk);
      if (insn_valid && done_en) begin
        repeat (done_dly) @(negedge clk);
        gemm_done = 1'b1;
        @(negedge clk);
        gemm_done = 1'b0;
        for (int n = 0; n < 50 && insn_valid; n++) @(negedge clk);
      end
    end
  end

  initial begin : token_driver
    forever begin
      @(negedge clk);
      if (rand_tok) begin
        prev_tok_in = ($urandom_range(0, 3) == 0);
        next_tok_in = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic send(input logic [127:0] d, output int acc, output logic acc_iv);
    int n = 0;
    @(negedge clk);
    s_if.s_insn_valid = 1'b1;
    s_if.s_insn_data  = d;
    while (!s_if.s_insn_ready && n < 500) begin @(negedge clk); n++; end
    acc = -1;
    acc_iv = 1'b0;
    if (n >= 500) begin
      chk("send_timeout", 1, 0);
      s_if.s_insn_valid = 1'b0;
      return;
    end
    acc_iv = insn_valid;
    model_push(d);
    @(posedge clk);
    #1;
    acc = cyc;
    s_if.s_insn_valid = 1'b0;
  endtask

  task automatic wait_rise(output int c);
    int n = 0;
    @(negedge clk);
    while (!insn_valid && n < 500) begin @(negedge clk); n++; end
    c = cyc;
    if (n >= 500) chk("rise_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || insn_valid) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [127:0] mk(input logic [2:0] op, input logic pp, input logic pn,
                                      input logic sp, input logic sn);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[2:0] = op; d[3] = pp; d[4] = pn; d[5] = sp; d[6] = sn;
    return d;
  endfunction

  // Pop-dependent insn must stall until its token arrives, then issue two edges after the grant.
  task automatic stall_then_token(input logic use_prev, input string name);
    int acc, c, t;
    logic iv;
    send(mk(3'h2, use_prev, !use_prev, 1'b0, 1'b0), acc, iv);
    repeat (10) @(negedge clk);
    chk({name, "_stall_valid"}, insn_valid, 0);
    chk({name, "_stall_busy"}, busy, 1);
    if (use_prev) prev_tok_in = 1'b1; else next_tok_in = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    @(negedge clk);
    prev_tok_in = 1'b0;
    next_tok_in = 1'b0;
    wait_rise(c);
    chk({name, "_rise_after_tok"}, c, t + 2);
    wait_idle();
  endtask

  initial begin : main
    int acc, c, p0;
    logic iv;
    logic [127:0] d;
    s_if.s_insn_valid = 1'b0;
    s_if.s_insn_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_tok_out", {prev_tok_out, next_tok_out}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", tok_overflow, 0);
    chk("rst_insn", insn, 0);
    rst = 1'b1;
    #1;
    chk("rst_ready", s_if.s_insn_ready, 1);

    // GEMM, no pop, push_next; done 5 cycles after valid rises.
    done_dly = 5;
    send(mk(3'h2, 0, 0, 0, 1), acc, iv);
    wait_rise(c);
    chk("t1_rise_edge2", c, acc + 2);
    wait_idle();
    chk("t1_next_pulse_count", n_next, 1);
    chk("t1_prev_pulse_count", n_prev, 0);
    chk("t1_push_after_done", last_next_cyc, done_cyc + 1);

    done_dly = 1;
    stall_then_token(1'b1, "t2");
    stall_then_token(1'b1, "t2b");

    // Sync-only opcode never reaches gemm and pushes at edge 2.
    p0 = n_prev;
    send(mk(3'h0, 0, 0, 1, 0), acc, iv);
    wait_idle();
    chk("t3_prev_pulse_count", n_prev, p0 + 1);
    chk("t3_prev_pulse_edge", last_prev_cyc, acc + 2);

    // Stray done while idle is ignored.
    @(negedge clk); gemm_done = 1'b1;
    @(negedge clk); gemm_done = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", busy, 0);

    // Saturate next counter, then drain all 15 tokens without stalls.
    @(negedge clk);
    next_tok_in = 1'b1;
    repeat (16) @(negedge clk);
    next_tok_in = 1'b0;
    chk("t4_overflow", tok_overflow, 1);
    for (int i = 0; i < 15; i++) begin
      send(mk(3'h2, 0, 1, 0, 0), acc, iv);
      wait_rise(c);
      chk("t4_no_stall", c, acc + 2);
      wait_idle();
    end
    stall_then_token(1'b0, "t4_empty");

    // Reset during ISSUE drops everything.
    done_en = 1'b0;
    send(mk(3'h2, 0, 0, 1, 1), acc, iv);
    wait_rise(c);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_async_valid_low", insn_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ready_after_rst", s_if.s_insn_ready, 1);
    chk("t5_overflow_cleared", tok_overflow, 0);
    p0 = n_prev + n_next;
    repeat (5) @(negedge clk);
    chk("t5_no_pulses", n_prev + n_next, p0);
    done_en = 1'b1;

`ifdef GEMM_ISSUE_SKID_EN
    done_dly = 3;
    send(mk(3'h2, 0, 0, 0, 1), acc, iv);
    wait_rise(c);
    send(mk(3'h2, 0, 0, 0, 0), acc, iv);
    chk("t6_accept_during_issue", iv, 1);
    for (int n = 0; n < 100 && insn_valid; n++) @(negedge clk);
    wait_rise(c);
    chk("t6_rerise", c, last_next_cyc + 2);
    wait_idle();
`endif

    // Randomised traffic against the scoreboard.
    rand_tok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      done_dly = $urandom_range(0, 4);
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) d[2:0] = 3'h2;
      else begin
        c = $urandom_range(0, 6);
        d[2:0] = (c >= 2) ? 3'(c + 1) : 3'(c);
      end
      send(d, acc, iv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_tok = 1'b0;
    prev_tok_in = 1'b0;
    next_tok_in = 1'b0;
    wait_idle();
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
